rr_stream_mux: RTL
==================

// Module: rr_stream_mux
// PURPOSE
//  - N-channel, WIDTH-bit stream multiplexer. Successor to the 4:1 select mux.
//  - Channel selection is a round-robin arbiter, not an external select.
//  - Each channel and the output use a valid/ready handshake; the output is registered.
//  - Sits between several producer streams and one shared consumer (bus, FIFO, UART TX).
// PARAMETERS
//  - N      default 4  number of input channels, N >= 2
//  - WIDTH  default 8  data width per channel
//  - SELW   default $clog2(N)  width of out_sel (derived, do not override)
// PORTS
//  - clk        in   1        single clock, rising edge
//  - rst_n      in   1        synchronous reset, active low
//  - in_data    in   N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
//  - in_valid   in   N        per-channel valid
//  - in_ready   out  N        per-channel ready, combinational, one-hot or zero
//  - out_data   out  WIDTH    registered output data
//  - out_valid  out  1        registered output valid
//  - out_ready  in   1        consumer ready
//  - out_sel    out  SELW     index of the channel that supplied out_data
//  - in_last    in   N        packet end, present only with RRMUX_PKT_LOCK_EN
//  - out_last   out  1        registered packet end, present only with RRMUX_PKT_LOCK_EN
// BEHAVIOUR
//  - Clock and reset: one clock `clk`. Reset is synchronous, active low on `rst_n`.
//  - Reset values: out_valid=0, out_data=0, out_sel=0, out_last=0, rr_ptr=0, lock=0.
//    While rst_n=0, in_ready=0 for all channels.
//  - Output stage:
//    - load_en = !out_valid || out_ready.
//    - The output register loads only when load_en=1 and a grant exists.
//    - When load_en=1 and no channel is valid, out_valid goes to 0 on the next edge.
//  - Arbitration (combinational, evaluated each cycle):
//    - g = first i with in_valid[i]=1, searching rr_ptr, rr_ptr+1, ... N-1, 0, ... (mod N).
//    - in_ready[g] = load_en. All other in_ready bits = 0.
//    - No valid channel: no grant, in_ready = 0.
//  - Transfer on channel g (in_valid[g] && in_ready[g]):
//    - Next edge: out_data <= in_data[g], out_sel <= g, out_valid <= 1.
//    - rr_ptr <= (g == N-1) ? 0 : g+1.
//  - Latency: 1 cycle from input transfer to out_valid. Throughput: 1 beat/cycle when out_ready=1.
//  - Backpressure (out_valid=1 && out_ready=0): out_data, out_sel, out_last held stable;
//    all in_ready=0; rr_ptr unchanged.
//  - Fairness: with all channels continuously valid, grants cycle 0,1,...,N-1,0.
//    No channel waits more than N-1 beats.
//  - Input valids may drop at any time without a transfer. The arbiter re-evaluates each cycle; there is no stored grant.
//  - Reset mid-transfer: a pending output beat is discarded; rr_ptr returns to 0.
// CONFIGURATION
//  - Macro RRMUX_PKT_LOCK_EN, defined: packet lock.
//    - Adds in_last and out_last.
//    - A transfer with in_last[g]=0 sets lock=1 and lock_ch=g.
//    - While lock=1, the grant is forced to lock_ch. Other channels see in_ready=0
//      even when lock_ch is not valid; in that case no grant is made.
//    - A transfer on lock_ch with in_last=1 clears lock. rr_ptr advances only on that beat.
//    - out_last <= in_last[g] on each transfer.
//  - Macro not defined: every beat is arbitrated independently.
//    No in_last/out_last ports; lock state is not built.
// TESTING
//  - T1 reset: rst_n=0 for 3 cycles, all in_valid=1 -> in_ready=0, out_valid=0, out_data=0.
//  - T2 fairness: N=4, all valid, in_data[i]=8'h10+i, out_ready=1
//    -> out_data 10,11,12,13,10 on consecutive cycles; out_sel 0,1,2,3,0.
//  - T3 single channel: only ch2 valid, in_data=8'hA5 -> out_valid=1 and out_data=A5,
//    out_sel=2 the cycle after; back-to-back every cycle.
//  - T4 backpressure: out_ready=0 for 3 cycles while out_valid=1 -> out_data/out_sel stable,
//    in_ready=0. On release, the next grant is rr_ptr order.
//  - T5 wrap: after a grant on ch3 (rr_ptr=0), ch1 and ch3 valid -> ch1 granted, then ch3.
//  - T6 (RRMUX_PKT_LOCK_EN): ch1 sends 3 beats, last on beat 3; ch0 valid throughout
//    -> out_sel 1,1,1 contiguous, out_last 0,0,1, then out_sel 0.

Source files
------------

// File: rtl/rr_stream_mux.sv
// rr_stream_mux: N-channel WIDTH-bit stream multiplexer with a round-robin
// arbiter and a registered valid/ready output stage.
// Optional packet lock: define RRMUX_PKT_LOCK_EN to add in_last/out_last and keep
// a channel granted until it delivers its packet-end beat.
module rr_stream_mux #(
  parameter int N     = 4,
  parameter int WIDTH = 8,
  parameter int SELW  = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SELW-1:0]    out_sel
`ifdef RRMUX_PKT_LOCK_EN
  ,
  input  logic [N-1:0]       in_last,
  output logic               out_last
`endif
);

  // Output register stage and arbitration pointer
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SELW-1:0]  out_sel_q,   out_sel_d;
  logic [SELW-1:0]  rr_ptr_q,    rr_ptr_d;

`ifdef RRMUX_PKT_LOCK_EN
  logic             lock_q,      lock_d;
  logic [SELW-1:0]  lock_ch_q,   lock_ch_d;
  logic             out_last_q,  out_last_d;
  logic             grant_last_s;
`endif

  logic             load_en_s;
  logic             grant_found_s;
  logic [SELW-1:0]  grant_idx_s;
  logic             xfer_s;
  logic             advance_s;
  logic [WIDTH-1:0] grant_data_s;
  logic             found_hi_s, found_lo_s;
  logic [SELW-1:0]  idx_hi_s,   idx_lo_s;

  // The output register can accept a new beat when empty or being drained
  assign load_en_s = !out_valid_q || out_ready;

  // Round-robin search: first valid at or above rr_ptr, else first valid overall
  always_comb begin
    found_hi_s = 1'b0;
    found_lo_s = 1'b0;
    idx_hi_s   = {SELW{1'b0}};
    idx_lo_s   = {SELW{1'b0}};
    for (int i = 0; i < N; i++) begin
      if (!found_hi_s && in_valid[i] && (SELW'(i) >= rr_ptr_q)) begin
        found_hi_s = 1'b1;
        idx_hi_s   = SELW'(i);
      end else begin
        found_hi_s = found_hi_s;
      end
      if (!found_lo_s && in_valid[i]) begin
        found_lo_s = 1'b1;
        idx_lo_s   = SELW'(i);
      end else begin
        found_lo_s = found_lo_s;
      end
    end
  end

  // Final grant selection; an active packet lock overrides the round-robin choice
  always_comb begin
    grant_found_s = found_hi_s || found_lo_s;
    if (found_hi_s) begin
      grant_idx_s = idx_hi_s;
    end else begin
      grant_idx_s = idx_lo_s;
    end
`ifdef RRMUX_PKT_LOCK_EN
    if (lock_q) begin
      // Locked channel only; others stay blocked even when it is idle
      grant_found_s = in_valid[lock_ch_q];
      grant_idx_s   = lock_ch_q;
    end else begin
      grant_found_s = grant_found_s;
    end
`endif
  end

  // A transfer happens when a grant exists and the output stage can load
  assign xfer_s = rst_n && load_en_s && grant_found_s;

  // Data mux and one-hot ready for the granted channel
  always_comb begin
    grant_data_s = {WIDTH{1'b0}};
    in_ready     = {N{1'b0}};
    for (int i = 0; i < N; i++) begin
      if (grant_idx_s == SELW'(i)) begin
        grant_data_s = in_data[i*WIDTH +: WIDTH];
        in_ready[i]  = xfer_s;
      end else begin
        in_ready[i]  = 1'b0;
      end
    end
  end

`ifdef RRMUX_PKT_LOCK_EN
  assign grant_last_s = in_last[grant_idx_s];
  // Pointer moves only when a packet completes
  assign advance_s    = xfer_s && grant_last_s;
`else
  assign advance_s    = xfer_s;
`endif

  // Next-state logic for the output stage, pointer and lock
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    rr_ptr_d    = rr_ptr_q;
`ifdef RRMUX_PKT_LOCK_EN
    lock_d      = lock_q;
    lock_ch_d   = lock_ch_q;
    out_last_d  = out_last_q;
`endif
    if (load_en_s) begin
      out_valid_d = xfer_s;
    end else begin
      out_valid_d = out_valid_q;
    end
    if (xfer_s) begin
      out_data_d = grant_data_s;
      out_sel_d  = grant_idx_s;
`ifdef RRMUX_PKT_LOCK_EN
      out_last_d = grant_last_s;
      lock_d     = !grant_last_s;
      lock_ch_d  = grant_idx_s;
`endif
    end else begin
      out_data_d = out_data_q;
    end
    if (advance_s) begin
      if (grant_idx_s == SELW'(N-1)) begin
        rr_ptr_d = {SELW{1'b0}};
      end else begin
        rr_ptr_d = grant_idx_s + SELW'(1);
      end
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= {WIDTH{1'b0}};
      out_sel_q   <= {SELW{1'b0}};
      rr_ptr_q    <= {SELW{1'b0}};
`ifdef RRMUX_PKT_LOCK_EN
      lock_q      <= 1'b0;
      lock_ch_q   <= {SELW{1'b0}};
      out_last_q  <= 1'b0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      rr_ptr_q    <= rr_ptr_d;
`ifdef RRMUX_PKT_LOCK_EN
      lock_q      <= lock_d;
      lock_ch_q   <= lock_ch_d;
      out_last_q  <= out_last_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
`ifdef RRMUX_PKT_LOCK_EN
  assign out_last  = out_last_q;
`endif

endmodule
